// File: rtl/comp_pkg.sv
// Shared definitions for the sequential digit-serial magnitude comparator.
package comp_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Counter width for ndig digits; never below one bit so NDIG=1 still has a counter.
  function automatic int cnt_width(input int ndig);
    int w;
    w = $clog2(ndig);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/comp_digit.sv
// Combinational magnitude comparator for one DIGIT-wide slice of the operands.
module comp_digit #(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] a_i,
  input  logic [DIGIT-1:0] b_i,
  output logic             gt_o,
  output logic             lt_o,
  output logic             eq_o
);

  assign gt_o = (a_i >  b_i);
  assign lt_o = (a_i <  b_i);
  assign eq_o = (a_i == b_i);

endmodule

// File: rtl/comp_nbit_seq.sv
// Multi-cycle magnitude comparator: scans operands DIGIT bits per cycle, MSB digit first,
// and reports registered GT/LT/EQ flags qualified by a one-cycle done pulse.
module comp_nbit_seq
  import comp_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int DIGIT      = 2,
  parameter int EARLY_EXIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             A_GT_B,
  output logic             A_LT_B,
  output logic             A_EQ_B
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = cnt_width(NDIG);
  localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

  if ((WIDTH < 1) || (DIGIT < 1) || (DIGIT > WIDTH) || ((WIDTH % DIGIT) != 0)) begin : g_bad_params
    $fatal(1, "comp_nbit_seq: DIGIT must be >= 1 and divide WIDTH");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             seen_q, seen_d;
  logic             sgt_q, sgt_d;
  logic             gt_q, gt_d, lt_q, lt_d, eq_q, eq_d;
  logic             done_q, done_d;
  logic             dig_gt, dig_lt, dig_eq;

  comp_digit #(.DIGIT(DIGIT)) u_digit (
    .a_i  (a_q[WIDTH-1 -: DIGIT]),
    .b_i  (b_q[WIDTH-1 -: DIGIT]),
    .gt_o (dig_gt),
    .lt_o (dig_lt),
    .eq_o (dig_eq)
  );

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    seen_d  = seen_q;
    sgt_d   = sgt_q;
    gt_d    = gt_q;
    lt_d    = lt_q;
    eq_d    = eq_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          // Flipping both sign bits maps two's-complement order onto unsigned order.
          a_d     = is_signed ? (a ^ MSB_MASK) : a;
          b_d     = is_signed ? (b ^ MSB_MASK) : b;
          cnt_d   = '0;
          seen_d  = 1'b0;
          sgt_d   = 1'b0;
        end
      end
      RUN: begin
        if (!dig_eq && !seen_q && (EARLY_EXIT != 0)) begin
          state_d = IDLE;
          done_d  = 1'b1;
          gt_d    = dig_gt;
          lt_d    = dig_lt;
          eq_d    = 1'b0;
        end else begin
          a_d   = a_q << DIGIT;
          b_d   = b_q << DIGIT;
          cnt_d = cnt_q + 1'b1;
          if (!dig_eq && !seen_q) begin
            seen_d = 1'b1;
            sgt_d  = dig_gt;
          end
          if (cnt_q == CW'(NDIG - 1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
            gt_d    = seen_d &&  sgt_d;
            lt_d    = seen_d && !sgt_d;
            eq_d    = !seen_d;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      seen_q  <= 1'b0;
      sgt_q   <= 1'b0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
      eq_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      seen_q  <= seen_d;
      sgt_q   <= sgt_d;
      gt_q    <= gt_d;
      lt_q    <= lt_d;
      eq_q    <= eq_d;
      done_q  <= done_d;
    end
  end

  // NOTE: operand shift registers carry no reset; they are always loaded on start before being read.
  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
  end

  assign busy   = (state_q == RUN);
  assign done   = done_q;
  assign A_GT_B = gt_q;
  assign A_LT_B = lt_q;
  assign A_EQ_B = eq_q;

endmodule

// File: tb/tb_comp_nbit_seq.sv
// Directed scoreboard bench for comp_nbit_seq (WIDTH=8, DIGIT=2) with early exit on and off.
module tb_comp_nbit_seq;

  localparam logic [2:0] GT = 3'b100;
  localparam logic [2:0] LT = 3'b010;
  localparam logic [2:0] EQ = 3'b001;

  typedef struct {
    logic [2:0] flags;
    int         lat;
    string      tag;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_ee = 1'b0, start_ne = 1'b0;
  logic       is_signed = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic       busy_ee, done_ee, gt_ee, lt_ee, eq_ee;
  logic       busy_ne, done_ne, gt_ne, lt_ne, eq_ne;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  comp_nbit_seq #(.WIDTH(8), .DIGIT(2), .EARLY_EXIT(1)) u_ee (
    .clk(clk), .rst(rst), .start(start_ee), .is_signed(is_signed), .a(a), .b(b),
    .busy(busy_ee), .done(done_ee), .A_GT_B(gt_ee), .A_LT_B(lt_ee), .A_EQ_B(eq_ee)
  );

  comp_nbit_seq #(.WIDTH(8), .DIGIT(2), .EARLY_EXIT(0)) u_ne (
    .clk(clk), .rst(rst), .start(start_ne), .is_signed(is_signed), .a(a), .b(b),
    .busy(busy_ne), .done(done_ne), .A_GT_B(gt_ne), .A_LT_B(lt_ne), .A_EQ_B(eq_ne)
  );

  function automatic logic [2:0] flags_of(input logic ne);
    return ne ? {gt_ne, lt_ne, eq_ne} : {gt_ee, lt_ee, eq_ee};
  endfunction

  function automatic logic done_of(input logic ne);
    return ne ? done_ne : done_ee;
  endfunction

  function automatic logic busy_of(input logic ne);
    return ne ? busy_ne : busy_ee;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // Drive one request (optionally right away, i.e. in a done cycle) and record its expected result.
  task automatic launch(input logic [7:0] ta, input logic [7:0] tb_, input logic ts, input logic ne,
                        input logic [2:0] eflags, input int elat, input string tag, input logic wait_neg);
    exp_t e;
    if (wait_neg) @(negedge clk);
    a = ta; b = tb_; is_signed = ts;
    if (ne) start_ne = 1'b1; else start_ee = 1'b1;
    e.flags = eflags; e.lat = elat; e.tag = tag;
    sb.push_back(e);
    @(posedge clk); #1;
    start_ee = 1'b0; start_ne = 1'b0;
    check({tag, "_busy_e0"}, 32'(busy_of(ne)), 32'd1);
  endtask

  // Wait (bounded) for done, then pop the scoreboard and compare latency, flags and busy.
  task automatic collect(input logic ne, input logic poke);
    int   cycles;
    exp_t e;
    cycles = 0;
    if (poke) begin
      a = 8'h80; b = 8'h01; is_signed = 1'b0; start_ee = 1'b1;
    end
    do begin
      @(posedge clk); #1;
      start_ee = 1'b0;
      cycles++;
    end while (!done_of(ne) && cycles < 20);
    e = sb.pop_front();
    check({e.tag, "_latency"}, 32'(cycles), 32'(e.lat));
    check({e.tag, "_flags"}, 32'(flags_of(ne)), 32'(e.flags));
    check({e.tag, "_busy_done"}, 32'(busy_of(ne)), 32'd0);
  endtask

  initial begin
    int dones;

    repeat (2) @(posedge clk);
    #1;
    check("reset_ee_busy", 32'(busy_ee), 32'd0);
    check("reset_ee_done", 32'(done_ee), 32'd0);
    check("reset_ee_flags", 32'(flags_of(1'b0)), 32'd0);
    check("reset_ne_flags", 32'({busy_ne, done_ne, gt_ne, lt_ne, eq_ne}), 32'd0);
    @(negedge clk); rst = 1'b0;

    launch(8'h1E, 8'h08, 1'b0, 1'b0, GT, 2, "gt_1e_08", 1'b1);        collect(1'b0, 1'b0);
    launch(8'h1E, 8'h08, 1'b0, 1'b1, GT, 4, "gt_1e_08_noee", 1'b1);   collect(1'b1, 1'b0);
    launch(8'h00, 8'h1E, 1'b0, 1'b0, LT, 2, "lt_00_1e", 1'b1);        collect(1'b0, 1'b0);
    launch(8'h0A, 8'h14, 1'b0, 1'b0, LT, 2, "lt_0a_14", 1'b1);        collect(1'b0, 1'b0);
    launch(8'h12, 8'h12, 1'b0, 1'b0, EQ, 4, "eq_12", 1'b1);           collect(1'b0, 1'b0);
    launch(8'h10, 8'h10, 1'b0, 1'b0, EQ, 4, "eq_10", 1'b1);           collect(1'b0, 1'b0);
    launch(8'h80, 8'h01, 1'b1, 1'b0, LT, 1, "s_80_01", 1'b1);         collect(1'b0, 1'b0);
    launch(8'h80, 8'h01, 1'b0, 1'b0, GT, 1, "u_80_01", 1'b1);         collect(1'b0, 1'b0);
    launch(8'h80, 8'h01, 1'b1, 1'b1, LT, 4, "s_80_01_noee", 1'b1);    collect(1'b1, 1'b0);
    launch(8'hFE, 8'hFF, 1'b1, 1'b0, LT, 4, "s_fe_ff", 1'b1);         collect(1'b0, 1'b0);
    launch(8'h12, 8'h12, 1'b0, 1'b1, EQ, 4, "eq_12_noee", 1'b1);      collect(1'b1, 1'b0);

    // Back-to-back: second start presented in the done cycle of the first.
    launch(8'h1E, 8'h08, 1'b0, 1'b0, GT, 2, "b2b_first", 1'b1);       collect(1'b0, 1'b0);
    launch(8'h0A, 8'h14, 1'b0, 1'b0, LT, 2, "b2b_second", 1'b0);      collect(1'b0, 1'b0);

    // A start pulse while busy must neither restart nor queue a second operation.
    launch(8'h12, 8'h12, 1'b0, 1'b0, EQ, 4, "busy_ignore", 1'b1);     collect(1'b0, 1'b1);
    dones = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (done_ee) dones++;
    end
    check("busy_ignore_no_extra_done", 32'(dones), 32'd0);
    check("busy_ignore_idle", 32'(busy_ee), 32'd0);
    check("busy_ignore_flags_hold", 32'(flags_of(1'b0)), 32'(EQ));

    // Prime flags with GT, then reset at E1 of an equal compare.
    launch(8'h80, 8'h01, 1'b0, 1'b0, GT, 1, "pre_rst", 1'b1);         collect(1'b0, 1'b0);
    @(negedge clk);
    a = 8'h12; b = 8'h12; is_signed = 1'b0; start_ee = 1'b1;
    @(posedge clk); #1;
    start_ee = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_mid_busy", 32'(busy_ee), 32'd0);
    check("rst_mid_done", 32'(done_ee), 32'd0);
    check("rst_mid_flags", 32'(flags_of(1'b0)), 32'd0);
    dones = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (done_ee) dones++;
    end
    check("rst_mid_no_done", 32'(dones), 32'd0);

    // Reset wins over a simultaneous start.
    @(negedge clk);
    rst = 1'b1; start_ee = 1'b1; a = 8'h12; b = 8'h34;
    @(posedge clk); #1;
    rst = 1'b0; start_ee = 1'b0;
    check("rst_vs_start_busy", 32'(busy_ee), 32'd0);

    launch(8'h0A, 8'h14, 1'b0, 1'b0, LT, 2, "after_rst", 1'b1);       collect(1'b0, 1'b0);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
